wb_cmd_master: RTL and testbench
================================

# wb_cmd_master

Synthesizable Wishbone initiator that drives the SD core's Wishbone slave register port from a simple command/stream interface. Executes single classic cycles or incrementing bursts of 1–8 beats, pulls write data and pushes read data on per-beat streams, and handles ERR, RTY and a no-response watchdog. Used by the on-chip controller and by system-level benches as the master end of the SD Wishbone slave.

## Interface
- gWidth, 32, data width of DAT_I/DAT_O/WrData/RdData
- gMaxRetries, 3, RTY terminations tolerated per beat before abort
- gTimeout, 255, cycles STB_O may stay high without ACK/ERR/RTY before abort

- CLK_I  in  1  clock; single clock domain
- RST_I  in  1  synchronous, active-high reset
- ReqValid  in  1  command valid
- ReqReady  out  1  high only in Idle
- ReqWrite  in  1  1 = write burst, 0 = read burst
- ReqAddr  in  3 [6:4]  start register address
- ReqLen  in  3  beats minus one (0 = single beat)
- WrValid / WrReady  in / out  1 / 1  write-data handshake
- WrData  in  gWidth  write beat data
- RdValid  out  1  one-cycle pulse per read beat
- RdData  out  gWidth  captured DAT_I
- RdLast  out  1  qualifies final read beat
- DoneValid  out  1  one-cycle pulse at end of command
- DoneErr  out  1  qualifies DoneValid: ERR, retry overflow or timeout
- CYC_O, STB_O, WE_O  out  1 each  Wishbone cycle, strobe, write enable
- ADR_O  out  3 [6:4]  register address
- DAT_O  out  gWidth  write data
- SEL_O  out  1  constant 1
- CTI_O  out  3  000 classic, 010 incrementing, 111 end-of-burst
- BTE_O  out  2  constant 00 (linear)
- ACK_I, ERR_I, RTY_I  in  1 each  slave terminations
- DAT_I  in  gWidth  read data

## Operation
- Reset value of all outputs 0 except ReqReady=1 and SEL_O=1; every Wishbone output is registered.
- States: Idle, WaitData, Beat, Backoff, Done.
- Idle: ReqValid&ReqReady latches write, address, beat counter = ReqLen. Read -> Beat. Write -> WaitData.
- WaitData: CYC_O=1, STB_O=0, WrReady=1. On WrValid, latch DAT_O -> Beat.
- Beat: CYC_O=STB_O=1, WE_O=write. CTI_O=000 if ReqLen=0; otherwise 010 on every beat except the last, which gets 111.
- ACK_I in Beat:
  - Read beat: latch DAT_I into RdData and pulse RdValid on the next cycle; RdLast is high with the last beat.
  - Not last beat: ADR_O increments modulo 8 (7 -> 0) and the beat counter decrements.
  - Not last read: stay in Beat.
  - Not last write: WrReady=1 combinationally during the ACK cycle. WrValid in that cycle -> stay in Beat with new DAT_O (zero wait states). Otherwise -> WaitData.
  - Last beat: drop CYC_O/STB_O -> Done.
- ERR_I in Beat: drop CYC_O/STB_O -> Done with DoneErr=1. Remaining beats are abandoned and no further RdValid is issued.
- RTY_I in Beat: increment the retry counter.
  - Counter exceeds gMaxRetries: abort as ERR.
  - Otherwise -> Backoff (STB_O=0, CYC_O=1 for one cycle), then reissue the same beat with the same ADR_O/DAT_O.
  - Retry counter clears on every ACK.
- Watchdog counts cycles in Beat since the last termination. Reaching gTimeout aborts as ERR.
- Done: DoneValid=1 for one cycle -> Idle.
- Priority when several terminations occur in one cycle: ERR > RTY > ACK.
- RST_I at any point, including mid-burst, forces the reset values at the next edge. No DoneValid is issued for the aborted command.

## Timing
- Read, handshake at cycle N: CYC_O/STB_O high in N+1. Single-beat ACK at cycle A -> RdValid at A+1, DoneValid at A+1, ReqReady at A+2.
- Write, WrValid in cycle M: STB_O high in M+1.
- Burst with zero wait states: one beat per cycle, CYC_O continuous.
- DoneValid coincides with RdValid/RdLast of the final read beat.
- Minimum command-to-command spacing: 3 cycles (Idle, Beat, Done).

## Test plan
- Single read of addr 5, slave ACKs with 0xDEADBEEF on the 2nd STB cycle -> CTI_O=000, RdData=0xDEADBEEF, RdLast=1, DoneValid with DoneErr=0, CYC_O low after ACK.
- 4-beat write from addr 6, WrValid always high, slave ACKs every cycle -> ADR_O 6,7,0,1 on consecutive cycles, CTI_O 010,010,010,111, DAT_O follows the WrData sequence.
- 3-beat read with WrValid irrelevant and slave inserting 2 wait states per beat -> 3 RdValid pulses with matching data, RdLast on the 3rd only.
- RTY on the first try then ACK -> one Backoff cycle with STB_O=0 and CYC_O=1, same ADR_O/DAT_O reissued, DoneErr=0. RTY 4 times with gMaxRetries=3 -> DoneErr=1.
- ERR on beat 2 of a 4-beat read -> exactly 1 RdValid, DoneErr=1, CYC_O low next cycle. Slave silent -> abort after gTimeout cycles with DoneErr=1.
- RST_I asserted mid-burst -> all outputs at reset values next cycle, no DoneValid, new command accepted afterward.

Source files
------------

// File: rtl/wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : wb_cmd_master
// Purpose  : Wishbone initiator running single or 1-8 beat incrementing bursts
// Revision : 1.0  initial release
// ============================================================================
module wb_cmd_master #(
  parameter int gWidth      = 32,
  parameter int gMaxRetries = 3,
  parameter int gTimeout    = 255
) (
  input  logic              CLK_I,
  input  logic              RST_I,
  input  logic              ReqValid,
  output logic              ReqReady,
  input  logic              ReqWrite,
  input  logic [6:4]        ReqAddr,
  input  logic [2:0]        ReqLen,
  input  logic              WrValid,
  output logic              WrReady,
  input  logic [gWidth-1:0] WrData,
  output logic              RdValid,
  output logic [gWidth-1:0] RdData,
  output logic              RdLast,
  output logic              DoneValid,
  output logic              DoneErr,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              WE_O,
  output logic [6:4]        ADR_O,
  output logic [gWidth-1:0] DAT_O,
  output logic              SEL_O,
  output logic [2:0]        CTI_O,
  output logic [1:0]        BTE_O,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic              RTY_I,
  input  logic [gWidth-1:0] DAT_I
);

  localparam int RW = $clog2(gMaxRetries + 2);
  localparam int WW = (gTimeout > 1) ? $clog2(gTimeout + 1) : 1;
  localparam logic [RW-1:0] MAX_RTY = RW'(gMaxRetries);
  localparam logic [WW-1:0] WD_LAST = WW'(gTimeout - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_BEAT = 3'd2,
    S_BACK = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic                we_q, we_d;
  logic [2:0]          adr_q, adr_d;
  logic [2:0]          cnt_q, cnt_d;
  logic                single_q, single_d;
  logic [gWidth-1:0]   dat_q, dat_d;
  logic [RW-1:0]       rty_q, rty_d;
  logic [WW-1:0]       wd_q, wd_d;
  logic                cyc_q, cyc_d;
  logic                stb_q, stb_d;
  logic [2:0]          cti_q, cti_d;
  logic                rdv_q, rdv_d;
  logic [gWidth-1:0]   rdd_q, rdd_d;
  logic                rdl_q, rdl_d;
  logic                donev_q, donev_d;
  logic                donee_q, donee_d;
  logic                wr_ready;
  logic                last_beat;
  logic [2:0]          cnt_dec;

  assign last_beat = (cnt_q == 3'd0);
  assign cnt_dec   = cnt_q - 3'd1;

  // Cycle type of the beat about to be presented, given beats left after it.
  function automatic logic [2:0] cti_for(input logic single, input logic [2:0] remaining);
    if (single) begin
      return 3'b000;
    end else if (remaining == 3'd0) begin
      return 3'b111;
    end else begin
      return 3'b010;
    end
  endfunction

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    adr_d    = adr_q;
    cnt_d    = cnt_q;
    single_d = single_q;
    dat_d    = dat_q;
    rty_d    = rty_q;
    wd_d     = '0;
    cyc_d    = cyc_q;
    stb_d    = stb_q;
    cti_d    = cti_q;
    rdv_d    = 1'b0;
    rdd_d    = rdd_q;
    rdl_d    = 1'b0;
    donev_d  = 1'b0;
    donee_d  = 1'b0;
    wr_ready = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (ReqValid) begin
          we_d     = ReqWrite;
          adr_d    = ReqAddr;
          cnt_d    = ReqLen;
          single_d = (ReqLen == 3'd0);
          rty_d    = '0;
          cyc_d    = 1'b1;
          if (ReqWrite) begin
            state_d = S_WAIT;
          end else begin
            stb_d   = 1'b1;
            cti_d   = cti_for(ReqLen == 3'd0, ReqLen);
            state_d = S_BEAT;
          end
        end
      end

      S_WAIT: begin
        wr_ready = 1'b1;
        if (WrValid) begin
          dat_d   = WrData;
          stb_d   = 1'b1;
          cti_d   = cti_for(single_q, cnt_q);
          state_d = S_BEAT;
        end
      end

      S_BEAT: begin
        // Terminations are resolved ERR > RTY > ACK; silence feeds the watchdog.
        if (ERR_I || (RTY_I && rty_q >= MAX_RTY) ||
            (!RTY_I && !ACK_I && wd_q == WD_LAST)) begin
          cyc_d   = 1'b0;
          stb_d   = 1'b0;
          donev_d = 1'b1;
          donee_d = 1'b1;
          state_d = S_DONE;
        end else if (RTY_I) begin
          rty_d   = rty_q + RW'(1);
          stb_d   = 1'b0;
          state_d = S_BACK;
        end else if (ACK_I) begin
          rty_d = '0;
          if (!we_q) begin
            rdv_d = 1'b1;
            rdd_d = DAT_I;
            rdl_d = last_beat;
          end
          if (last_beat) begin
            cyc_d   = 1'b0;
            stb_d   = 1'b0;
            donev_d = 1'b1;
            state_d = S_DONE;
          end else begin
            adr_d = adr_q + 3'd1;
            cnt_d = cnt_dec;
            cti_d = cti_for(single_q, cnt_dec);
            if (we_q) begin
              // Next write word may be taken in the ACK cycle for zero wait states.
              wr_ready = 1'b1;
              if (WrValid) begin
                dat_d = WrData;
              end else begin
                stb_d   = 1'b0;
                state_d = S_WAIT;
              end
            end
          end
        end else begin
          wd_d = wd_q + WW'(1);
        end
      end

      S_BACK: begin
        stb_d   = 1'b1;
        state_d = S_BEAT;
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
        cyc_d   = 1'b0;
        stb_d   = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q  <= S_IDLE;
      we_q     <= 1'b0;
      adr_q    <= 3'd0;
      cnt_q    <= 3'd0;
      single_q <= 1'b0;
      dat_q    <= '0;
      rty_q    <= '0;
      wd_q     <= '0;
      cyc_q    <= 1'b0;
      stb_q    <= 1'b0;
      cti_q    <= 3'd0;
      rdv_q    <= 1'b0;
      rdd_q    <= '0;
      rdl_q    <= 1'b0;
      donev_q  <= 1'b0;
      donee_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      adr_q    <= adr_d;
      cnt_q    <= cnt_d;
      single_q <= single_d;
      dat_q    <= dat_d;
      rty_q    <= rty_d;
      wd_q     <= wd_d;
      cyc_q    <= cyc_d;
      stb_q    <= stb_d;
      cti_q    <= cti_d;
      rdv_q    <= rdv_d;
      rdd_q    <= rdd_d;
      rdl_q    <= rdl_d;
      donev_q  <= donev_d;
      donee_q  <= donee_d;
    end
  end

  assign ReqReady  = (state_q == S_IDLE);
  assign WrReady   = wr_ready;
  assign RdValid   = rdv_q;
  assign RdData    = rdd_q;
  assign RdLast    = rdl_q;
  assign DoneValid = donev_q;
  assign DoneErr   = donee_q;
  assign CYC_O     = cyc_q;
  assign STB_O     = stb_q;
  assign WE_O      = we_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign SEL_O     = 1'b1;
  assign CTI_O     = cti_q;
  assign BTE_O     = 2'b00;

endmodule
`default_nettype wire

// File: tb/tb_wb_cmd_master.sv
`default_nettype none
// ============================================================================
// Module   : tb_wb_cmd_master
// Purpose  : Self-checking bench for wb_cmd_master with a transaction model
// Revision : 1.0  initial release
// ============================================================================
module tb_wb_cmd_master;

  localparam int W    = 32;
  localparam int MAXR = 3;
  localparam int TO   = 16;

  logic          clk = 1'b0;
  logic          RST_I = 1'b1;
  logic          ReqValid = 1'b0, ReqWrite = 1'b0;
  logic [2:0]    ReqAddr = 3'd0, ReqLen = 3'd0;
  logic          WrValid = 1'b0;
  logic [W-1:0]  WrData = '0;
  logic          ACK_I = 1'b0, ERR_I = 1'b0, RTY_I = 1'b0;
  logic [W-1:0]  DAT_I = '0;
  logic          ReqReady, WrReady, RdValid, RdLast, DoneValid, DoneErr;
  logic [W-1:0]  RdData, DAT_O;
  logic          CYC_O, STB_O, WE_O, SEL_O;
  logic [2:0]    ADR_O, CTI_O;
  logic [1:0]    BTE_O;

  always #5 clk = ~clk;

  wb_cmd_master #(.gWidth(W), .gMaxRetries(MAXR), .gTimeout(TO)) dut (
    .CLK_I(clk), .RST_I(RST_I), .ReqValid(ReqValid), .ReqReady(ReqReady),
    .ReqWrite(ReqWrite), .ReqAddr(ReqAddr), .ReqLen(ReqLen),
    .WrValid(WrValid), .WrReady(WrReady), .WrData(WrData),
    .RdValid(RdValid), .RdData(RdData), .RdLast(RdLast),
    .DoneValid(DoneValid), .DoneErr(DoneErr),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O), .DAT_O(DAT_O),
    .SEL_O(SEL_O), .CTI_O(CTI_O), .BTE_O(BTE_O),
    .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I), .DAT_I(DAT_I)
  );

  typedef struct { int cyc; logic [2:0] a; logic [2:0] c; logic [W-1:0] d; logic l; } ent_t;
  typedef struct { int code; logic [W-1:0] d; } rsp_t;   // 0 wait, 1 ack, 2 err, 3 rty

  ent_t slog[$];
  ent_t rlog[$];
  ent_t dlog[$];
  rsp_t script[$];
  int   slv_mode = 1;   // 0 random responder, 1 silent once the script runs dry
  int   wr_mode  = 1;   // 0 random write stream, 1 always valid with indexed data
  int   wbase    = 0;
  int   nacc_total = 0;
  int   total = 0;
  int   bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave responder
  always @(posedge clk) begin : p_slave
    rsp_t x;
    int   p;
    #1;
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    DAT_I = $urandom;
    if (STB_O === 1'b1) begin
      if (script.size() > 0) begin
        x = script.pop_front();
        DAT_I = x.d;
        case (x.code)
          1: ACK_I = 1'b1;
          2: ERR_I = 1'b1;
          3: RTY_I = 1'b1;
          default: ;
        endcase
      end else if (slv_mode == 0) begin
        p = $urandom_range(0, 99);
        if (p < 50)      ACK_I = 1'b1;
        else if (p < 75) ACK_I = 1'b0;
        else if (p < 82) RTY_I = 1'b1;
        else if (p < 86) ERR_I = 1'b1;
        else if (p < 92) {ACK_I, ERR_I, RTY_I} = 3'($urandom);
      end
    end
  end

  // Write-data stream
  always @(posedge clk) begin : p_wr
    #1;
    if (wr_mode == 1) begin
      WrValid = 1'b1;
      WrData  = 32'hA0 + 32'(nacc_total - wbase);
    end else begin
      WrValid = ($urandom_range(0, 2) != 0);
      WrData  = $urandom;
    end
  end

  // Transaction-level reference model and per-cycle comparison
  bit           busy = 0, cw = 0;
  logic [2:0]   ca = 3'd0;
  int           cl = 0, k = 0, r = 0, s = 0, nacc = 0, cyc = 0;
  logic [W-1:0] wd [8];
  bit           e_stb = 0, e_back = 0, e_done = 0, e_err = 0, e_rdv = 0, e_rdl = 0;
  bit           rst_seen = 1;
  logic [W-1:0] e_rdd = '0;

  always @(negedge clk) begin : p_cmp
    logic [2:0]   ea, ec;
    bit           ewr, b0, nstb, nback, ndone, nerr, nrdv, nrdl;
    logic [W-1:0] nrdd;
    ent_t         e;
    cyc++;
    if (STB_O === 1'b1) begin
      e.cyc = cyc; e.a = ADR_O; e.c = CTI_O; e.d = DAT_O; e.l = 1'b0; slog.push_back(e);
    end
    if (RdValid === 1'b1) begin
      e.cyc = cyc; e.a = 3'd0; e.c = 3'd0; e.d = RdData; e.l = RdLast; rlog.push_back(e);
    end
    if (DoneValid === 1'b1) begin
      e.cyc = cyc; e.a = 3'd0; e.c = 3'd0; e.d = {31'd0, CYC_O}; e.l = DoneErr; dlog.push_back(e);
    end

    ea  = 3'((int'(ca) + k) % 8);
    ec  = (cl == 0) ? 3'd0 : ((k == cl) ? 3'd7 : 3'd2);
    ewr = busy && cw && !e_done &&
          ((!e_stb && !e_back) || (e_stb && ACK_I && !ERR_I && !RTY_I && k != cl));

    if (rst_seen) begin
      chk("rst_wb", 64'({CYC_O, STB_O, WE_O, ADR_O, CTI_O, BTE_O}), 64'd0);
      chk("rst_sel", 64'(SEL_O), 64'd1);
      chk("rst_stream", 64'({WrReady, RdValid, RdLast, DoneValid, DoneErr}), 64'd0);
      chk("rst_reqready", 64'(ReqReady), 64'd1);
      chk("rst_data", 64'({DAT_O, RdData}), 64'd0);
    end else begin
      chk("ReqReady", 64'(ReqReady), 64'(!busy));
      chk("CYC_O", 64'(CYC_O), 64'(busy && !e_done));
      chk("STB_O", 64'(STB_O), 64'(e_stb));
      chk("WrReady", 64'(WrReady), 64'(ewr));
      chk("DoneValid", 64'(DoneValid), 64'(e_done));
      if (e_done) chk("DoneErr", 64'(DoneErr), 64'(e_err));
      chk("RdValid", 64'(RdValid), 64'(e_rdv));
      if (e_rdv) begin
        chk("RdData", 64'(RdData), 64'(e_rdd));
        chk("RdLast", 64'(RdLast), 64'(e_rdl));
      end
      if (e_stb) begin
        chk("ADR_O", 64'(ADR_O), 64'(ea));
        chk("CTI_O", 64'(CTI_O), 64'(ec));
        chk("WE_O", 64'(WE_O), 64'(cw));
        if (cw) chk("DAT_O", 64'(DAT_O), 64'(wd[k % 8]));
      end
    end

    nstb = 0; nback = 0; ndone = 0; nerr = 0; nrdv = 0; nrdl = 0; nrdd = e_rdd;
    if (RST_I === 1'b1) begin
      busy = 0;
      rst_seen = 1;
    end else begin
      rst_seen = 0;
      b0 = busy;
      if (e_done) busy = 0;
      if (!b0) begin
        if (ReqValid === 1'b1) begin
          busy = 1; cw = ReqWrite; ca = ReqAddr; cl = int'(ReqLen);
          k = 0; r = 0; s = 0; nacc = 0;
          nstb = !ReqWrite;
        end
      end else if (!e_done) begin
        if (ewr && WrValid) begin
          wd[nacc % 8] = WrData;
          nacc++;
          nacc_total++;
          nstb = 1;
        end
        if (e_stb) begin
          if (ERR_I) begin
            ndone = 1; nerr = 1;
          end else if (RTY_I) begin
            r++; s = 0;
            if (r > MAXR) begin ndone = 1; nerr = 1; end
            else nback = 1;
          end else if (ACK_I) begin
            r = 0; s = 0;
            if (!cw) begin nrdv = 1; nrdd = DAT_I; nrdl = (k == cl); end
            if (k == cl) ndone = 1;
            else begin
              k++;
              if (!cw) nstb = 1;
            end
          end else begin
            s++;
            if (s == TO) begin ndone = 1; nerr = 1; end
            else nstb = 1;
          end
        end
        if (e_back) nstb = 1;
      end
    end
    e_stb = nstb; e_back = nback; e_done = ndone; e_err = nerr;
    e_rdv = nrdv; e_rdd = nrdd; e_rdl = nrdl;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_rsp(input int code, input logic [W-1:0] d);
    rsp_t x;
    x.code = code; x.d = d;
    script.push_back(x);
  endtask

  task automatic send(input bit w, input logic [2:0] a, input logic [2:0] l);
    int n = 0;
    while (ReqReady !== 1'b1 && n < 200) begin tick(); n++; end
    chk("req_ready_wait", 64'(ReqReady), 64'd1);
    ReqValid = 1'b1; ReqWrite = w; ReqAddr = a; ReqLen = l;
    tick();
    ReqValid = 1'b0;
  endtask

  task automatic wait_done(input int db);
    int n = 0;
    while (dlog.size() <= db && n < 400) begin tick(); n++; end
    chk("done_seen", 64'(dlog.size() > db), 64'd1);
    tick();
  endtask

  initial begin : p_host
    int sb, rb, db;
    logic [2:0] adr4 [4];
    logic [2:0] cti4 [4];
    adr4 = '{3'd6, 3'd7, 3'd0, 3'd1};
    cti4 = '{3'd2, 3'd2, 3'd2, 3'd7};
    tick(); tick();
    RST_I = 1'b0;
    tick();

    // Single read at 5, ACK with 0xDEADBEEF on the second strobe cycle
    sb = slog.size(); rb = rlog.size(); db = dlog.size();
    push_rsp(0, 32'h0); push_rsp(1, 32'hDEADBEEF);
    send(0, 3'd5, 3'd0);
    wait_done(db);
    chk("t1_nstb", 64'(slog.size() - sb), 64'd2);
    chk("t1_adr", 64'(slog[sb].a), 64'd5);
    chk("t1_cti", 64'(slog[sb+1].c), 64'd0);
    chk("t1_rdata", 64'(rlog[rb].d), 64'hDEADBEEF);
    chk("t1_rdlast", 64'(rlog[rb].l), 64'd1);
    chk("t1_done_with_rd", 64'(dlog[db].cyc), 64'(rlog[rb].cyc));
    chk("t1_err", 64'(dlog[db].l), 64'd0);
    chk("t1_cyc_low", 64'(dlog[db].d[0]), 64'd0);

    // 4-beat write from 6, zero wait states
    sb = slog.size(); db = dlog.size(); wbase = nacc_total;
    repeat (4) push_rsp(1, 32'h0);
    send(1, 3'd6, 3'd3);
    wait_done(db);
    chk("t2_nstb", 64'(slog.size() - sb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      chk("t2_adr", 64'(slog[sb+i].a), 64'(adr4[i]));
      chk("t2_cti", 64'(slog[sb+i].c), 64'(cti4[i]));
      chk("t2_dat", 64'(slog[sb+i].d), 64'(32'hA0 + 32'(i)));
    end
    chk("t2_back_to_back", 64'(slog[sb+3].cyc - slog[sb].cyc), 64'd3);
    chk("t2_err", 64'(dlog[db].l), 64'd0);

    // 3-beat read with two wait states per beat
    rb = rlog.size(); db = dlog.size();
    for (int i = 1; i <= 3; i++) begin
      push_rsp(0, 32'h0); push_rsp(0, 32'h0); push_rsp(1, 32'h111 * 32'(i));
    end
    send(0, 3'd2, 3'd2);
    wait_done(db);
    chk("t3_nrd", 64'(rlog.size() - rb), 64'd3);
    for (int i = 0; i < 3; i++) begin
      chk("t3_rdata", 64'(rlog[rb+i].d), 64'(32'h111 * 32'(i + 1)));
      chk("t3_rdlast", 64'(rlog[rb+i].l), 64'(i == 2));
    end

    // RTY then ACK on a single write: backoff then identical reissue
    sb = slog.size(); db = dlog.size(); wbase = nacc_total;
    push_rsp(3, 32'h0); push_rsp(1, 32'h0);
    send(1, 3'd3, 3'd0);
    wait_done(db);
    chk("t4_nstb", 64'(slog.size() - sb), 64'd2);
    chk("t4_gap", 64'(slog[sb+1].cyc - slog[sb].cyc), 64'd2);
    chk("t4_adr_same", 64'({slog[sb].a, slog[sb+1].a}), 64'({3'd3, 3'd3}));
    chk("t4_dat_same", 64'({slog[sb].d, slog[sb+1].d}), 64'({32'hA0, 32'hA0}));
    chk("t4_err", 64'(dlog[db].l), 64'd0);

    // Exactly gMaxRetries RTYs are tolerated
    db = dlog.size();
    repeat (3) push_rsp(3, 32'h0);
    push_rsp(1, 32'h5);
    send(0, 3'd1, 3'd0);
    wait_done(db);
    chk("t4_max_ok", 64'(dlog[db].l), 64'd0);

    // One RTY too many aborts
    sb = slog.size(); db = dlog.size();
    repeat (4) push_rsp(3, 32'h0);
    send(0, 3'd1, 3'd0);
    wait_done(db);
    chk("t4_over_err", 64'(dlog[db].l), 64'd1);
    chk("t4_over_nstb", 64'(slog.size() - sb), 64'd4);

    // ERR on beat 2 of a 4-beat read
    rb = rlog.size(); db = dlog.size();
    push_rsp(1, 32'h77); push_rsp(2, 32'h0);
    send(0, 3'd0, 3'd3);
    wait_done(db);
    chk("t5_nrd", 64'(rlog.size() - rb), 64'd1);
    chk("t5_err", 64'(dlog[db].l), 64'd1);
    chk("t5_cyc_low", 64'(dlog[db].d[0]), 64'd0);

    // Silent slave: watchdog abort after TO strobe cycles
    sb = slog.size(); db = dlog.size();
    send(0, 3'd7, 3'd0);
    wait_done(db);
    chk("t6_nstb", 64'(slog.size() - sb), 64'(TO));
    chk("t6_err", 64'(dlog[db].l), 64'd1);

    // Reset mid-burst, then a fresh command
    db = dlog.size();
    repeat (3) push_rsp(1, 32'h9);
    repeat (4) push_rsp(0, 32'h0);
    send(0, 3'd0, 3'd7);
    repeat (4) tick();
    RST_I = 1'b1;
    tick();
    RST_I = 1'b0;
    script.delete();
    repeat (6) tick();
    chk("t7_no_done", 64'(dlog.size() - db), 64'd0);
    rb = rlog.size();
    push_rsp(1, 32'hCAFE0001);
    send(0, 3'd4, 3'd0);
    wait_done(db);
    chk("t7_err", 64'(dlog[db].l), 64'd0);
    chk("t7_rdata", 64'(rlog[rb].d), 64'hCAFE0001);

    // Randomized traffic against the model
    slv_mode = 0; wr_mode = 0; db = dlog.size();
    for (int i = 0; i < 4000; i++) begin
      ReqValid = 1'($urandom);
      ReqWrite = 1'($urandom);
      ReqAddr  = 3'($urandom);
      ReqLen   = 3'($urandom);
      RST_I    = ($urandom_range(0, 499) == 0);
      tick();
    end
    ReqValid = 1'b0; RST_I = 1'b0;
    repeat (40) tick();
    chk("rand_cmds_done", 64'(dlog.size() - db > 50), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
